// File: rtl/mc_core_pkg.sv
// Shared definitions for the multi-cycle core: opcode/funct codes, sequencer
// states and the ALU operation encoding.
package mc_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add/sub/and/or/signed-less-than with zero, negative and
// signed-overflow flags of the selected result.
module mc_alu
  import mc_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              v
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = sum;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        v      = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff;
        v      = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

endmodule

// File: rtl/mc_core_param.sv
// Multi-cycle MIPS-subset core with handshaked instruction/data ports, registered
// Z/N/V status, hardwired zero register and a HALT state left only by reset.
module mc_core_param
  import mc_core_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_CNT  = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        status,
  output logic              halted
);

  localparam int              RA_W     = $clog2(REG_CNT);
  localparam logic [RA_W-1:0] LINK_REG = RA_W'(REG_CNT - 1);

  state_t            state, state_n;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] regs [REG_CNT];

  logic [5:0]        opcode, funct;
  logic [RA_W-1:0]   rs, rt, rd, wb_dst;
  logic [DATA_W-1:0] imm, rd_a, rd_b, alu_b, alu_result, wb_data;
  logic [ADDR_W-1:0] br_off, jump_pc;
  alu_op_t           alu_op;
  logic              rtype_ok, is_mem, alu_z, alu_n, alu_v;

  assign opcode  = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[21 +: RA_W];
  assign rt      = ir[16 +: RA_W];
  assign rd      = ir[11 +: RA_W];
  assign imm     = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign br_off  = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
  // pc already points past the jump, so its upper nibble is that of the delay slot
  assign jump_pc = {pc[ADDR_W-1:28], ir[25:0], 2'b00};

  assign rd_a    = (rs == '0) ? '0 : regs[rs];
  assign rd_b    = (rt == '0) ? '0 : regs[rt];
  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
  assign alu_b   = is_mem ? imm : b_q;

  assign wb_dst  = (opcode == OP_LW) ? rt : rd;
  assign wb_data = (opcode == OP_LW) ? mdr : alu_q;

  assign imem_addr  = pc;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = b_q;

  always_comb begin
    alu_op   = ALU_ADD;
    rtype_ok = 1'b0;
    if (opcode == OP_RTYPE) begin
      rtype_ok = 1'b1;
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: rtype_ok = 1'b0;
      endcase
    end else if (opcode == OP_BEQ) begin
      alu_op = ALU_SUB;
    end
  end

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n),
    .v      (alu_v)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Requests are masked during reset so an abandoned access drops immediately.
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = !reset;
        if (imem_ready) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE:     state_n = rtype_ok ? S_WB : S_FETCH;
          OP_LW, OP_SW: state_n = S_MEM;
          OP_HALT:      state_n = S_HALT;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = !reset;
        dmem_we  = !reset && (opcode == OP_SW);
        if (dmem_ready) state_n = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  halted  = !reset;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      addr_q <= '0;
      mdr    <= '0;
      status <= '0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        S_EXEC: begin
          alu_q  <= alu_result;
          addr_q <= ADDR_W'(alu_result);
          if (rtype_ok || opcode == OP_BEQ) status <= {alu_v, alu_n, alu_z};
          if (opcode == OP_BEQ && alu_z) pc <= pc + br_off;
          if (opcode == OP_J || opcode == OP_JAL) pc <= jump_pc;
          if (opcode == OP_JAL && LINK_REG != '0) regs[LINK_REG] <= DATA_W'(pc);
        end
        S_MEM: begin
          if (dmem_ready && opcode == OP_LW) mdr <= dmem_rdata;
        end
        S_WB: begin
          if (wb_dst != '0) regs[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_param.sv
// Bench for mc_core_param: directed and random instruction streams with random
// memory latency, compared against an instruction-level reference model.
module tb_mc_core_param;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic [2:0]  status;
  logic        halted;

  mc_core_param #(
    .DATA_W(32), .REG_CNT(32), .ADDR_W(32), .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .status     (status),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Architectural reference state
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [2:0]  m_status;
  logic [31:0] dmem [logic [31:0]];
  bit          have_prev;
  int          prev_t0, prev_cycles;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!dmem.exists(a)) dmem[a] = $urandom;
    return dmem[a];
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Flags from the exact (unwrapped) value and the wrapped 32-bit result.
  function automatic logic [2:0] flags(input longint exact, input logic [31:0] res, input bit ovf_ok);
    bit v;
    v = ovf_ok && (exact != longint'($signed(res)));
    return {v, res[31], res == 32'h0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc      = RST_PC;
    m_status  = 3'b000;
    have_prev = 0;
  endtask

  // kind: 0 no memory access, 1 load, 2 store, 3 halt
  task automatic model_exec(input logic [31:0] ins, output int kind, output int ncyc,
                            output logic [31:0] maddr, output logic [31:0] mwdata);
    int          rs, rt, rd;
    logic [31:0] a, b, res, pc4, sx, nxt;
    longint      exact;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    a = m_reg[rs];
    b = m_reg[rt];
    pc4 = m_pc + 32'd4;
    sx = {{16{ins[15]}}, ins[15:0]};
    nxt = pc4;
    kind = 0;
    ncyc = 3;
    maddr = 32'h0;
    mwdata = 32'h0;
    res = 32'h0;
    exact = 0;
    case (ins[31:26])
      6'h00: begin
        ncyc = 4;
        case (ins[5:0])
          6'h20: begin exact = longint'($signed(a)) + longint'($signed(b)); res = a + b; end
          6'h22: begin exact = longint'($signed(a)) - longint'($signed(b)); res = a - b; end
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ncyc = 3;
        endcase
        if (ncyc == 4) begin
          m_reg[rd] = res;
          m_status = flags(exact, res, ins[5:0] == 6'h20 || ins[5:0] == 6'h22);
        end
      end
      6'h23: begin kind = 1; ncyc = 5; maddr = a + sx; end
      6'h2B: begin kind = 2; ncyc = 4; maddr = a + sx; mwdata = b; end
      6'h04: begin
        exact = longint'($signed(a)) - longint'($signed(b));
        res = a - b;
        m_status = flags(exact, res, 1'b1);
        if (res == 32'h0) nxt = pc4 + (sx * 4);
      end
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        nxt = {pc4[31:28], ins[25:0], 2'b00};
        m_reg[31] = pc4;
      end
      6'h3F: kind = 3;
      default: ;
    endcase
    m_reg[0] = 32'h0;
    m_pc = nxt;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (imem_req) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait, input bit rst_in_mem);
    bit          ok;
    int          kind, ncyc, rt;
    logic [31:0] maddr, mwdata, ldata;
    wait_fetch(ok);
    chk("fetch_seen", 32'(ok), 32'd1);
    if (!ok) return;
    if (have_prev) chk("cycles", 32'(cyc - prev_t0), 32'(prev_cycles));
    chk("pc", pc, m_pc);
    chk("status", 32'(status), 32'(m_status));
    chk("imem_addr", imem_addr, m_pc);
    prev_t0 = cyc;
    for (int w = 0; w < iwait; w++) begin
      dmem_ready = 1'($urandom);
      @(negedge clk);
      chk("imem_req_hold", 32'(imem_req), 32'd1);
      chk("imem_addr_hold", imem_addr, m_pc);
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    model_exec(ins, kind, ncyc, maddr, mwdata);
    prev_cycles = ncyc + iwait + ((kind == 1 || kind == 2) ? dwait : 0);
    have_prev = 1;
    if (kind == 3) begin
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
        if (halted) ok = 1;
        else @(negedge clk);
      end
      chk("halted", 32'(halted), 32'd1);
      chk("halt_latency", 32'(cyc - prev_t0), 32'(3 + iwait));
      for (int i = 0; i < 20; i++) begin
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        @(negedge clk);
        chk("halt_imem_req", 32'(imem_req), 32'd0);
        chk("halt_dmem_req", 32'(dmem_req), 32'd0);
        chk("halt_pc", pc, m_pc);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      have_prev = 0;
    end else if (kind != 0) begin
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
        if (dmem_req) ok = 1;
        else @(negedge clk);
      end
      chk("dmem_req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      chk("dmem_we", 32'(dmem_we), 32'(kind == 2));
      chk("dmem_addr", dmem_addr, maddr);
      if (kind == 2) chk("dmem_wdata", dmem_wdata, mwdata);
      for (int w = 0; w < dwait; w++) begin
        if (rst_in_mem && w == 2) begin
          imem_ready = 1'b0;
          reset = 1'b1;
          @(negedge clk);
          chk("midmem_rst_pc", pc, RST_PC);
          chk("midmem_rst_dmem_req", 32'(dmem_req), 32'd0);
          chk("midmem_rst_imem_req", 32'(imem_req), 32'd0);
          reset = 1'b0;
          model_reset();
          @(negedge clk);
          return;
        end
        imem_ready = 1'($urandom);
        @(negedge clk);
        chk("dmem_req_hold", 32'(dmem_req), 32'd1);
        chk("dmem_we_hold", 32'(dmem_we), 32'(kind == 2));
        chk("dmem_addr_hold", dmem_addr, maddr);
        if (kind == 2) chk("dmem_wdata_hold", dmem_wdata, mwdata);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b1;
      ldata = (kind == 1) ? mem_rd(maddr) : $urandom;
      dmem_rdata = ldata;
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      rt = int'(ins[20:16]);
      if (kind == 2) dmem[maddr] = mwdata;
      else if (rt != 0) m_reg[rt] = ldata;
    end
  endtask

  task automatic do_reset();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_status", 32'(status), 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    int          r  = $urandom_range(0, 99);
    int          rs = $urandom_range(0, 31);
    int          rt = $urandom_range(0, 31);
    int          rd = $urandom_range(0, 31);
    logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    logic [5:0]  nops [3] = '{6'h08, 6'h0D, 6'h3E};
    logic [15:0] imm = 16'($urandom);
    if (r < 40) return enc_r(rs, rt, rd, fns[$urandom_range(0, 5)]);
    if (r < 55) return enc_i(6'h23, rs, rt, imm);
    if (r < 70) return enc_i(6'h2B, rs, rt, imm);
    if (r < 80) begin
      if ($urandom_range(0, 1) == 1) rt = rs;
      return enc_i(6'h04, rs, rt, imm);
    end
    if (r < 87) return enc_j(6'h02, 26'($urandom));
    if (r < 93) return enc_j(6'h03, 26'($urandom));
    return {nops[$urandom_range(0, 2)], 26'($urandom)};
  endfunction

  function automatic int rnd_wait();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
  endfunction

  bit ok_main;

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    imem_rdata = 32'h0;
    dmem_rdata = 32'h0;
    dmem[32'h0]  = 32'd5;
    dmem[32'h4]  = 32'd7;
    dmem[32'hC]  = 32'h7FFF_FFFF;
    dmem[32'h10] = 32'd1;
    model_reset();
    @(negedge clk);
    do_reset();

    run_instr(enc_i(6'h23, 0, 1, 16'h0000), 0, 0, 0);
    wait_fetch(ok_main);
    chk("first_pc", pc, 32'h4);
    run_instr(enc_i(6'h23, 0, 2, 16'h0004), 0, 0, 0);
    run_instr(enc_r(1, 2, 3, 6'h20), 0, 0, 0);
    wait_fetch(ok_main);
    chk("add_status", 32'(status), 32'd0);
    run_instr(enc_i(6'h2B, 0, 3, 16'h0014), 0, 0, 0);
    run_instr(enc_r(1, 1, 4, 6'h22), 0, 0, 0);
    wait_fetch(ok_main);
    chk("sub_zero_status", 32'(status), 32'b001);
    run_instr(enc_i(6'h23, 0, 6, 16'h000C), 0, 0, 0);
    run_instr(enc_i(6'h23, 0, 7, 16'h0010), 0, 0, 0);
    run_instr(enc_r(6, 7, 8, 6'h20), 0, 0, 0);
    wait_fetch(ok_main);
    chk("ovf_status", 32'(status), 32'b110);
    run_instr(enc_i(6'h23, 0, 9, 16'h0000), 3, 3, 0);
    wait_fetch(ok_main);
    chk("lw_wait_cycles", 32'(cyc - prev_t0), 32'd11);
    run_instr(enc_i(6'h2B, 0, 2, 16'h0008), 0, 0, 0);
    run_instr(enc_i(6'h23, 0, 5, 16'h0008), 0, 0, 0);
    run_instr(enc_i(6'h2B, 0, 5, 16'h0018), 0, 1, 0);
    run_instr(enc_r(1, 2, 0, 6'h20), 0, 0, 0);
    run_instr(enc_i(6'h2B, 0, 0, 16'h001C), 0, 0, 0);
    run_instr(enc_j(6'h02, 26'h4), 0, 0, 0);
    run_instr(enc_i(6'h04, 1, 1, 16'hFFFF), 0, 0, 0);
    wait_fetch(ok_main);
    chk("beq_self_pc", pc, 32'h10);
    run_instr(enc_j(6'h02, 26'h8), 0, 0, 0);
    run_instr(enc_j(6'h03, 26'h40), 0, 0, 0);
    wait_fetch(ok_main);
    chk("jal_pc", pc, 32'h100);
    run_instr(enc_i(6'h2B, 0, 31, 16'h0020), 0, 0, 0);

    for (int i = 0; i < 350; i++) run_instr(gen_instr(), rnd_wait(), rnd_wait(), 0);

    run_instr(enc_j(6'h3F, 26'h0), 1, 0, 0);
    do_reset();
    for (int i = 0; i < 30; i++) run_instr(gen_instr(), rnd_wait(), rnd_wait(), 0);
    run_instr(enc_i(6'h2B, 0, 0, 16'h0040), 0, 5, 1);
    for (int i = 0; i < 30; i++) run_instr(gen_instr(), rnd_wait(), rnd_wait(), 0);
    wait_fetch(ok_main);
    chk("final_pc", pc, m_pc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
